// File: rtl/restoring_divider.sv
// restoring_divider: sequential shift-subtract unsigned divider, one quotient bit per clock
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   src1       dividend (DIVIDEND_W bits), captured on the load edge
//   src2       divisor (DIVISOR_W bits), captured on the load edge
//   start      request; accepted in IDLE or DONE, ignored while calculating
//   quotient   src1 / src2, all ones when src2 == 0
//   remainder  src1 % src2, src1[DIVISOR_W-1:0] when src2 == 0
//   valid      level: result held stable until the next accepted start
//   busy       division in progress
//   div_zero   present only with DIV_ZERO_FLAG_EN: the completed division had a zero divisor
module restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIVIDEND_W-1:0] src1,
  input  logic [DIVISOR_W-1:0]  src2,
  input  logic                  start,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  valid,
  output logic                  busy
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  div_zero
`endif
);
  localparam int CW = DIVIDEND_W > 1 ? $clog2(DIVIDEND_W) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic load, step, last, ge;
  logic [CW-1:0] cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0] dvs;
  logic [DIVISOR_W:0] pr, trial, pr_n;
  logic unused_pr_msb;
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CALC : IDLE;
      CALC:    state_n = cnt == CW'(DIVIDEND_W-1) ? DONE : CALC;
      DONE:    state_n = start ? CALC : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    load = start && (state == IDLE || state == DONE);
    step = state == CALC;
    last = step && cnt == CW'(DIVIDEND_W-1);
  end
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial = {pr[DIVISOR_W-1:0], dvd[DIVIDEND_W-1]};
  assign ge = trial >= {1'b0, dvs};
  assign pr_n = ge ? trial - {1'b0, dvs} : trial;
  // after a subtract the remainder is below the divisor, so the top bit never feeds the next shift
  assign unused_pr_msb = pr[DIVISOR_W];
  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd <= '0;
      dvs <= '0;
      pr <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else if (load) begin
      dvd <= src1;
      dvs <= src2;
      pr <= '0;
      cnt <= '0;
      valid <= 1'b0;
      busy <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else if (step) begin
      dvd <= {dvd[DIVIDEND_W-2:0], ge};
      pr <= pr_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= {dvd[DIVIDEND_W-2:0], ge};
        remainder <= pr_n[DIVISOR_W-1:0];
        valid <= 1'b1;
        busy <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        div_zero <= dvs == '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for restoring_divider against an arithmetic reference model
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] src1 = '0;
  logic [3:0] src2 = '0;
  logic start = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic valid, busy;
`ifdef DIV_ZERO_FLAG_EN
  logic div_zero;
`endif
  typedef struct {
    logic [7:0] s1;
    logic [3:0] s2;
    int due;
  } item_t;
  item_t sb[$];
  item_t it;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic pv = 1'b0;
  logic [11:0] ex;
  restoring_divider dut (
    .clk(clk),
    .rst(rst),
    .src1(src1),
    .src2(src2),
    .start(start),
    .quotient(quotient),
    .remainder(remainder),
    .valid(valid),
    .busy(busy)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [11:0] model(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] q;
    logic [3:0] r;
    q = b == 0 ? 8'hFF : 8'(a / b);
    r = b == 0 ? a[3:0] : 4'(a % b);
    return {q, r};
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (valid && !pv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 required no pending operation");
      end else begin
        it = sb.pop_front();
        ex = model(it.s1, it.s2);
        chk("quotient", int'(quotient), int'(ex[11:4]));
        chk("remainder", int'(remainder), int'(ex[3:0]));
        chk("latency", cyc, it.due);
        chk("busy_at_valid", int'(busy), 0);
        if (it.s2 != 0)
          chk("invariant", int'(int'(quotient) * int'(it.s2) + int'(remainder) == int'(it.s1) && remainder < it.s2), 1);
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero", int'(div_zero), int'(it.s2 == 0));
`endif
      end
    end
    pv <= valid;
  end
  task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit keep);
    @(negedge clk);
    src1 = a;
    src2 = b;
    start = 1'b1;
    if (keep) sb.push_back('{a, b, cyc + 9});
    @(negedge clk);
    start = 1'b0;
    src1 = 8'($urandom);
    src2 = 4'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no completion required finish within budget");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef DIV_ZERO_FLAG_EN
    chk("rst_div_zero", int'(div_zero), 0);
`endif
    issue(8'd200, 4'd7, 1);
    chk("busy_in_calc", int'(busy), 1);
    drain();
    issue(8'd255, 4'd1, 1);
    drain();
    issue(8'd5, 4'd9, 1);
    drain();
    issue(8'hA6, 4'd0, 1);
    drain();
    issue(8'd143, 4'd11, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    src1 = 8'd9;
    src2 = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", int'(busy), 1);
    chk("valid_after_ignored_start", int'(valid), 0);
    drain();
    issue(8'd77, 4'd3, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    repeat (12) @(negedge clk);
    chk("midrst_valid_later", int'(valid), 0);
    for (int k = 0; k < 20; k++) begin
      issue(8'($urandom), 4'($urandom_range(0, 15)), 1);
      drain();
    end
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      src1 = 8'($urandom);
      src2 = 4'($urandom);
      start = 1'b1;
      sb.push_back('{src1, src2, cyc + 9});
      repeat (9) @(negedge clk);
    end
    start = 1'b0;
    drain();
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b), 1);
        drain();
      end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
